// File: rtl/ele_uart_pkg.sv
// Shared types and helpers for the framed UART transmitter.
package ele_uart_pkg;

  // Transmit sequencer states: wait for a start, header, payload, trailer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Widest frame the transmitter can be built for (255 payload bytes).
  localparam int MAX_FRAME_BYTES = 255;
  localparam int MAX_FRAME_BITS  = 8 * MAX_FRAME_BYTES;

  // Reverse the low 'width' bits of value; bits at and above 'width' come
  // back as zero. Callers zero-extend into and truncate out of the
  // maximum width, so one function serves every frame size.
  function automatic logic [MAX_FRAME_BITS-1:0] bit_reverse(
    input logic [MAX_FRAME_BITS-1:0] value,
    input int                        width
  );
    logic [MAX_FRAME_BITS-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_FRAME_BITS; i++) begin
      if (i < width) begin
        result[11'(i)] = value[11'(width - 1 - i)];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ele_frame_change_det.sv
// Decides when a new frame may start: always, or only when the status word
// differs from the last frame sent or a forced resend is pending.
module ele_frame_change_det #(
  parameter int FRAME_W   = 120,
  parameter bit ON_CHANGE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame,
  input  logic               force_send,
  input  logic               take,
  output logic               start_req
);

  logic [FRAME_W-1:0] last_sent_reg;
  logic               force_pending_reg;

  // Remember the word taken at each frame start; a force request arriving
  // at any time (even during a take) leaves one frame owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sent_reg     <= '0;
      force_pending_reg <= 1'b0;
    end else begin
      if (take) begin
        last_sent_reg <= frame;
      end
      if (ON_CHANGE && force_send) begin
        force_pending_reg <= 1'b1;
      end else if (take) begin
        force_pending_reg <= 1'b0;
      end
    end
  end

  assign start_req = ON_CHANGE ? ((frame != last_sent_reg) || force_pending_reg) : 1'b1;

endmodule

// File: rtl/ele_frame_uart_tx.sv
// Framed transmitter: snapshots a status word and feeds it byte by byte,
// wrapped in a sync header and optional XOR trailer, to a UART byte sender.
module ele_frame_uart_tx
  import ele_uart_pkg::*;
#(
  parameter int         FRAME_BYTES = 15,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter bit         ON_CHANGE   = 1'b0,
  parameter bit         BIT_REVERSE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] frame,
  input  logic                     force_send,
  input  logic                     uart_ready,
  output logic [7:0]               uart_data,
  output logic                     uart_en,
  output logic                     busy,
  output logic [15:0]              frames_sent
);

  localparam int FRAME_W = 8 * FRAME_BYTES;
  localparam int IDX_W   = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  tx_state_t          state_reg;
  logic [FRAME_W-1:0] shadow_reg;
  logic [7:0]         csum_reg;
  logic [IDX_W-1:0]   byte_idx_reg;

  logic               start_req;
  logic               take;
  logic               issue;
  logic [FRAME_W-1:0] snap_value;
  logic [7:0]         cur_byte;

  // Snapshot value: optionally mirror the whole word before byte slicing.
  generate
    if (BIT_REVERSE) begin : g_rev
      assign snap_value = FRAME_W'(bit_reverse(MAX_FRAME_BITS'(frame), FRAME_W));
    end else begin : g_norev
      assign snap_value = frame;
    end
  endgenerate

  ele_frame_change_det #(
    .FRAME_W  (FRAME_W),
    .ON_CHANGE(ON_CHANGE)
  ) u_change_det (
    .clk       (clk),
    .reset     (reset),
    .frame     (frame),
    .force_send(force_send),
    .take      (take),
    .start_req (start_req)
  );

  assign take = (state_reg == IDLE) && start_req;

  // The uart_en guard covers the cycle in which the sender has not yet
  // dropped ready after accepting our strobe, so a byte never goes twice.
  assign issue = uart_ready && !uart_en;

  // Payload byte k sits at shadow[8k+7:8k].
  assign cur_byte = 8'(shadow_reg >> {byte_idx_reg, 3'b000});

  // Frame sequencer with registered strobe, data, busy and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      shadow_reg   <= '0;
      csum_reg     <= '0;
      byte_idx_reg <= '0;
      uart_data    <= '0;
      uart_en      <= 1'b0;
      busy         <= 1'b0;
      frames_sent  <= '0;
    end else begin
      uart_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_req) begin
            state_reg    <= HDR;
            shadow_reg   <= snap_value;
            csum_reg     <= '0;
            byte_idx_reg <= '0;
            busy         <= 1'b1;
          end
        end
        HDR: begin
          if (issue) begin
            uart_data <= SYNC_BYTE;
            uart_en   <= 1'b1;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (issue) begin
            uart_data    <= cur_byte;
            uart_en      <= 1'b1;
            csum_reg     <= csum_reg ^ cur_byte;
            byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            if (byte_idx_reg == LAST_IDX) begin
              if (CHECKSUM_EN) begin
                state_reg <= CSUM;
              end else begin
                state_reg   <= IDLE;
                busy        <= 1'b0;
                frames_sent <= frames_sent + 16'd1;
              end
            end
          end
        end
        CSUM: begin
          if (issue) begin
            uart_data   <= csum_reg;
            uart_en     <= 1'b1;
            state_reg   <= IDLE;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ele_frame_uart_tx.sv
// Bench for ele_frame_uart_tx: four parameterisations driven side by side.
module tb_ele_frame_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: 2 bytes, no reverse, checksum, continuous
  logic rst_a = 1'b1, force_a = 1'b0, ready_a = 1'b1;
  logic [15:0] frame_a = '0;
  logic [7:0] data_a; logic en_a, busy_a; logic [15:0] fs_a;
  // B: 2 bytes, no reverse, checksum, on-change
  logic rst_b = 1'b1, force_b = 1'b0, ready_b = 1'b1;
  logic [15:0] frame_b = '0;
  logic [7:0] data_b; logic en_b, busy_b; logic [15:0] fs_b;
  // C: 1 byte, reversed, no checksum, continuous
  logic rst_c = 1'b1, force_c = 1'b0, ready_c = 1'b1;
  logic [7:0] frame_c = '0;
  logic [7:0] data_c; logic en_c, busy_c; logic [15:0] fs_c;
  // D: 3 bytes, reversed, checksum, continuous, random sender
  logic rst_d = 1'b1, force_d = 1'b0, ready_d = 1'b1;
  logic [23:0] frame_d = '0;
  logic [7:0] data_d; logic en_d, busy_d; logic [15:0] fs_d;

  ele_frame_uart_tx #(.FRAME_BYTES(2), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1), .ON_CHANGE(1'b0), .BIT_REVERSE(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .frame(frame_a), .force_send(force_a), .uart_ready(ready_a),
    .uart_data(data_a), .uart_en(en_a), .busy(busy_a), .frames_sent(fs_a));
  ele_frame_uart_tx #(.FRAME_BYTES(2), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1), .ON_CHANGE(1'b1), .BIT_REVERSE(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .frame(frame_b), .force_send(force_b), .uart_ready(ready_b),
    .uart_data(data_b), .uart_en(en_b), .busy(busy_b), .frames_sent(fs_b));
  ele_frame_uart_tx #(.FRAME_BYTES(1), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0), .ON_CHANGE(1'b0), .BIT_REVERSE(1'b1)) dut_c (
    .clk(clk), .reset(rst_c), .frame(frame_c), .force_send(force_c), .uart_ready(ready_c),
    .uart_data(data_c), .uart_en(en_c), .busy(busy_c), .frames_sent(fs_c));
  ele_frame_uart_tx #(.FRAME_BYTES(3), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1), .ON_CHANGE(1'b0), .BIT_REVERSE(1'b1)) dut_d (
    .clk(clk), .reset(rst_d), .frame(frame_d), .force_send(force_d), .uart_ready(ready_d),
    .uart_data(data_d), .uart_en(en_d), .busy(busy_d), .frames_sent(fs_d));

  logic [7:0] cap_a[$], cap_b[$], cap_c[$], exp_d[$];
  int  delay_a = 0, cnt_a = 0, busy_viol_a = 0;
  bit  busy_chk_a = 1'b0;
  bit  d_active = 1'b0;
  int  pos_d = 0, frames_d = 0, cnt_d = 0;

  typedef struct { logic [15:0] frame; logic [31:0] bytes; } vec2_t;
  typedef struct { logic [7:0] frame; logic [7:0] rev; } vec1_t;
  vec2_t tab_a[5];
  vec1_t tab_c[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int w);
    case (w)
      0:       return cap_a.size();
      1:       return cap_b.size();
      default: return cap_c.size();
    endcase
  endfunction

  function automatic logic [7:0] qbyte(input int w, input int i);
    if (i >= qsize(w)) return 8'hxx;
    case (w)
      0:       return cap_a[i];
      1:       return cap_b[i];
      default: return cap_c[i];
    endcase
  endfunction

  // Wait (at negedges) until at least n strobes are captured, bounded.
  task automatic wait_q(input int w, input int n, input int budget, input string name);
    int k = 0;
    while (qsize(w) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, " strobe count reached"}, 32'(qsize(w) >= n), 32'd1);
  endtask

  task automatic chk_frame(input int w, input int start, input logic [31:0] eb, input string name);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s byte%0d", name, k), 32'(qbyte(w, start + k)), 32'(eb[31-8*k -: 8]));
    end
  endtask

  task automatic restart(input int w, input logic [23:0] f);
    case (w)
      0:       begin rst_a = 1'b1; frame_a = f[15:0]; end
      1:       begin rst_b = 1'b1; frame_b = f[15:0]; end
      default: begin rst_c = 1'b1; frame_c = f[7:0]; end
    endcase
    repeat (2) @(negedge clk);
    case (w)
      0:       begin cap_a.delete(); rst_a = 1'b0; end
      1:       begin cap_b.delete(); rst_b = 1'b0; end
      default: begin cap_c.delete(); rst_c = 1'b0; end
    endcase
  endtask

  // Reference model: header, payload bytes of the mirrored word LSB first, XOR.
  task automatic model_push(input logic [23:0] f);
    logic [23:0] r;
    logic [7:0]  x, b;
    for (int i = 0; i < 24; i++) r[i] = f[23-i];
    exp_d.push_back(8'hA5);
    x = 8'h00;
    for (int k = 0; k < 3; k++) begin
      b = r[8*k +: 8];
      exp_d.push_back(b);
      x ^= b;
    end
    exp_d.push_back(x);
  endtask

  // Monitors and sender models for A, B, C (sampled 1ns after posedge).
  initial forever begin
    @(posedge clk); #1;
    if (en_a) begin
      cap_a.push_back(data_a);
      if (delay_a > 0) begin ready_a = 1'b0; cnt_a = delay_a; end
    end else if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) ready_a = 1'b1;
    end
    if (busy_chk_a && (cap_a.size() % 4) != 0 && !busy_a) busy_viol_a++;
    if (en_b) cap_b.push_back(data_b);
    if (en_c) cap_c.push_back(data_c);
  end

  // D: random sender, new random word after each frame, per-byte scoreboard.
  initial forever begin
    logic [7:0] expb;
    @(posedge clk); #1;
    if (d_active) begin
      if (en_d) begin
        expb = (exp_d.size() == 0) ? 8'hxx : exp_d.pop_front();
        $display("rand frame %0d byte %0d: %02h (model %02h)", frames_d, pos_d, data_d, expb);
        chk("rand byte", 32'(data_d), 32'(expb));
        pos_d++;
        if (pos_d == 5) begin
          pos_d = 0;
          frames_d++;
          chk("rand busy at last strobe", 32'(busy_d), 32'd0);
          chk("rand frames_sent", 32'(fs_d), 32'(16'(frames_d)));
          frame_d = 24'($urandom);
          model_push(frame_d);
        end else begin
          chk("rand busy mid frame", 32'(busy_d), 32'd1);
        end
        ready_d = 1'b0;
        cnt_d = $urandom_range(0, 4);
        if (cnt_d == 0) ready_d = 1'b1;
      end else if (cnt_d > 0) begin
        cnt_d--;
        if (cnt_d == 0) ready_d = 1'b1;
      end
    end
  end

  initial begin
    int lat;
    int k;
    tab_a[0] = '{16'h1234, 32'hA5341226};
    tab_a[1] = '{16'h0000, 32'hA5000000};
    tab_a[2] = '{16'hFFFF, 32'hA5FFFF00};
    tab_a[3] = '{16'h00A5, 32'hA5A500A5};
    tab_a[4] = '{16'h8001, 32'hA5018081};
    tab_c[0] = '{8'h01, 8'h80};
    tab_c[1] = '{8'h80, 8'h01};
    tab_c[2] = '{8'h0F, 8'hF0};
    tab_c[3] = '{8'h3C, 8'h3C};
    tab_c[4] = '{8'hC2, 8'h43};
    tab_c[5] = '{8'h1D, 8'hB8};

    repeat (3) @(negedge clk);
    chk("reset uart_en", 32'(en_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset uart_data", 32'(data_a), 32'd0);
    chk("reset frames_sent", 32'(fs_a), 32'd0);

    // Header strobe two cycles after the start decision.
    restart(0, 24'h001234);
    lat = 0;
    while (qsize(0) == 0 && lat < 20) begin @(negedge clk); lat++; end
    $display("header latency %0d cycles", lat);
    chk("header latency", 32'(lat), 32'd2);

    // Table: A frames with ready held high.
    for (int i = 0; i < 5; i++) begin
      restart(0, 24'(tab_a[i].frame));
      wait_q(0, 5, 100, "tab_a");
      $display("tab_a frame %04h: %02h %02h %02h %02h %02h fs=%0d", tab_a[i].frame,
               qbyte(0, 0), qbyte(0, 1), qbyte(0, 2), qbyte(0, 3), qbyte(0, 4), fs_a);
      chk_frame(0, 0, tab_a[i].bytes, "tab_a");
      chk("tab_a next header", 32'(qbyte(0, 4)), 32'hA5);
      chk("tab_a frames_sent", 32'(fs_a), 32'd1);
    end

    // Table: C single byte, reversed, no trailer.
    for (int i = 0; i < 6; i++) begin
      restart(2, 24'(tab_c[i].frame));
      wait_q(2, 3, 100, "tab_c");
      $display("tab_c frame %02h: %02h %02h %02h fs=%0d", tab_c[i].frame,
               qbyte(2, 0), qbyte(2, 1), qbyte(2, 2), fs_c);
      chk("tab_c header", 32'(qbyte(2, 0)), 32'hA5);
      chk("tab_c payload", 32'(qbyte(2, 1)), 32'(tab_c[i].rev));
      chk("tab_c no trailer", 32'(qbyte(2, 2)), 32'hA5);
      chk("tab_c frames_sent", 32'(fs_c), 32'd1);
      chk("tab_c busy", 32'(busy_c), 32'd1);
    end

    // Reset in the middle of the second frame.
    restart(0, 24'h001234);
    wait_q(0, 5, 100, "midreset");
    rst_a = 1'b1;
    @(negedge clk);
    $display("mid-frame reset: en=%0d busy=%0d fs=%0d", en_a, busy_a, fs_a);
    chk("midreset uart_en", 32'(en_a), 32'd0);
    chk("midreset busy", 32'(busy_a), 32'd0);
    chk("midreset frames_sent", 32'(fs_a), 32'd0);
    repeat (4) @(negedge clk);
    chk("midreset no strobes", 32'(qsize(0)), 32'd5);
    rst_a = 1'b0;
    wait_q(0, 7, 100, "midreset restart");
    chk("midreset restart header", 32'(qbyte(0, 5)), 32'hA5);
    chk("midreset restart byte0", 32'(qbyte(0, 6)), 32'h34);

    // Slow sender: ready low for 100 cycles after each strobe.
    delay_a = 100;
    restart(0, 24'h001234);
    busy_chk_a = 1'b1;
    wait_q(0, 8, 1500, "slow");
    busy_chk_a = 1'b0;
    delay_a = 0;
    $display("slow sender: %0d strobes fs=%0d busy drops=%0d", qsize(0), fs_a, busy_viol_a);
    chk_frame(0, 0, 32'hA5341226, "slow f0");
    chk_frame(0, 4, 32'hA5341226, "slow f1");
    chk("slow frames_sent", 32'(fs_a), 32'd2);
    chk("slow busy held", 32'(busy_viol_a), 32'd0);

    // On-change: one frame, then silence.
    restart(1, 24'h0000FF);
    wait_q(1, 4, 100, "onchg first");
    repeat (60) @(negedge clk);
    $display("onchg first: %0d strobes fs=%0d", qsize(1), fs_b);
    chk("onchg silence count", 32'(qsize(1)), 32'd4);
    chk_frame(1, 0, 32'hA5FF00FF, "onchg first");
    chk("onchg first frames_sent", 32'(fs_b), 32'd1);
    chk("onchg idle busy", 32'(busy_b), 32'd0);
    // Changed word: exactly one new frame.
    frame_b = 16'h0100;
    wait_q(1, 8, 100, "onchg change");
    repeat (60) @(negedge clk);
    $display("onchg change: %0d strobes fs=%0d", qsize(1), fs_b);
    chk("onchg change count", 32'(qsize(1)), 32'd8);
    chk_frame(1, 4, 32'hA5000101, "onchg change");
    chk("onchg change frames_sent", 32'(fs_b), 32'd2);
    // Force with unchanged word: one frame.
    force_b = 1'b1;
    @(negedge clk);
    force_b = 1'b0;
    wait_q(1, 12, 100, "onchg force");
    repeat (60) @(negedge clk);
    $display("onchg force: %0d strobes fs=%0d", qsize(1), fs_b);
    chk("onchg force count", 32'(qsize(1)), 32'd12);
    chk_frame(1, 8, 32'hA5000101, "onchg force");
    chk("onchg force frames_sent", 32'(fs_b), 32'd3);
    // Force during a frame: exactly one extra frame afterwards.
    frame_b = 16'h0200;
    wait_q(1, 13, 100, "onchg midforce start");
    force_b = 1'b1;
    @(negedge clk);
    force_b = 1'b0;
    wait_q(1, 20, 200, "onchg midforce");
    repeat (60) @(negedge clk);
    $display("onchg midforce: %0d strobes fs=%0d", qsize(1), fs_b);
    chk("onchg midforce count", 32'(qsize(1)), 32'd20);
    chk_frame(1, 12, 32'hA5000202, "onchg midforce f0");
    chk_frame(1, 16, 32'hA5000202, "onchg midforce f1");
    chk("onchg midforce frames_sent", 32'(fs_b), 32'd5);

    // Randomised frames against the reference model.
    frame_d = 24'($urandom);
    model_push(frame_d);
    repeat (2) @(negedge clk);
    d_active = 1'b1;
    rst_d = 1'b0;
    k = 0;
    while (frames_d < 150 && k < 20000) begin @(negedge clk); k++; end
    d_active = 1'b0;
    chk("rand frames completed", 32'(frames_d >= 150), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
